// File: rtl/debounce_one_shot_multi.sv
// Multi-channel button debouncer: 2-flop synchroniser, separate rise/fall
// stability thresholds, debounced level and a restartable one-shot pulse per channel.
`timescale 1ns/1ps
module debounce_one_shot_multi #(
  parameter int N          = 4,
  parameter int CNT_W      = 8,
  parameter int RISE_CLKS  = 25,
  parameter int FALL_CLKS  = 50,
  parameter int PULSE_CLKS = 3,
  parameter int MODE       = 0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] BTN,
  output logic [N-1:0] DB_LEVEL,
  output logic [N-1:0] DB_PULSE,
  output logic         ANY_PULSE
);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_LOW_TO_HIGH,
    ST_HIGH,
    ST_HIGH_TO_LOW
  } state_t;

  // Any MODE other than 1 or 2 falls back to release-only pulsing.
  localparam logic             PRESS_EN   = (MODE == 1) || (MODE == 2);
  localparam logic             RELEASE_EN = (MODE != 1);
  localparam logic [CNT_W:0]   RISE_TH    = (CNT_W + 1)'(RISE_CLKS);
  localparam logic [CNT_W:0]   FALL_TH    = (CNT_W + 1)'(FALL_CLKS);
  localparam logic [CNT_W-1:0] PULSE_TH   = CNT_W'(PULSE_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [N-1:0] sync1_q, sync2_q;
  logic [N-1:0] pulse_d;
  logic         any_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      any_q   <= 1'b0;
    end else begin
      sync1_q <= BTN;
      sync2_q <= sync1_q;
      any_q   <= |pulse_d;
    end
  end

  assign ANY_PULSE = any_q;

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic             level_q, level_d, pulse_q, pulse_nxt;
    logic             rise_ev, fall_ev, illegal, s;

    assign s       = sync2_q[i];
    // One bit wider than the counter so the threshold compare can never wrap.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_ev = 1'b0;
      fall_ev = 1'b0;
      illegal = 1'b0;
      case (state_q)
        ST_LOW: begin
          cnt_d = '0;
          if (s) begin
            if (RISE_CLKS == 1) begin
              state_d = ST_HIGH;
              level_d = 1'b1;
              rise_ev = 1'b1;
            end else begin
              state_d = ST_LOW_TO_HIGH;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_LOW_TO_HIGH: begin
          if (!s) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_inc == RISE_TH) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_ev = 1'b1;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        ST_HIGH: begin
          cnt_d = '0;
          if (!s) begin
            if (FALL_CLKS == 1) begin
              state_d = ST_LOW;
              level_d = 1'b0;
              fall_ev = 1'b1;
            end else begin
              state_d = ST_HIGH_TO_LOW;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_HIGH_TO_LOW: begin
          if (s) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_inc == FALL_TH) begin
            state_d = ST_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_ev = 1'b1;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          illegal = 1'b1;
        end
      endcase
    end

    // A fresh qualifying event restarts the pulse even if one is in flight.
    always_comb begin
      pulse_nxt = pulse_q;
      pcnt_d    = pcnt_q;
      if (illegal) begin
        pulse_nxt = 1'b0;
        pcnt_d    = '0;
      end else if ((rise_ev && PRESS_EN) || (fall_ev && RELEASE_EN)) begin
        pulse_nxt = 1'b1;
        pcnt_d    = CNT_ONE;
      end else if (pulse_q) begin
        if (pcnt_q == PULSE_TH) begin
          pulse_nxt = 1'b0;
          pcnt_d    = '0;
        end else begin
          pcnt_d = pcnt_q + CNT_ONE;
        end
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q <= ST_LOW;
        cnt_q   <= '0;
        pcnt_q  <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pcnt_q  <= pcnt_d;
        level_q <= level_d;
        pulse_q <= pulse_nxt;
      end
    end

    assign DB_LEVEL[i] = level_q;
    assign DB_PULSE[i] = pulse_q;
    assign pulse_d[i]  = pulse_nxt;
  end

endmodule

// File: tb/tb_debounce_one_shot_multi.sv
// Bench for debounce_one_shot_multi: four differently-parameterised instances
// checked against a sample-history reference model, plus directed corner cases.
`timescale 1ns/1ps
module tb_debounce_one_shot_multi;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] btn     [NI];
  logic [1:0] dut_lvl [NI];
  logic [1:0] dut_pls [NI];
  logic       dut_any [NI];

  // Instance parameters: 0 press-mode, 1 release-mode, 2 both/long pulse, 3 boundary
  int r_th   [NI] = '{4, 4, 4, 1};
  int f_th   [NI] = '{6, 6, 3, 15};
  int p_len  [NI] = '{2, 2, 8, 1};
  int mode_v [NI] = '{1, 0, 2, 2};

  always #5 clk = ~clk;

  debounce_one_shot_multi #(.N(2), .CNT_W(8), .RISE_CLKS(4), .FALL_CLKS(6), .PULSE_CLKS(2), .MODE(1)) u_m1 (
    .CLK(clk), .RST_N(rst_n), .BTN(btn[0]), .DB_LEVEL(dut_lvl[0]), .DB_PULSE(dut_pls[0]), .ANY_PULSE(dut_any[0]));
  debounce_one_shot_multi #(.N(2), .CNT_W(8), .RISE_CLKS(4), .FALL_CLKS(6), .PULSE_CLKS(2), .MODE(0)) u_m0 (
    .CLK(clk), .RST_N(rst_n), .BTN(btn[1]), .DB_LEVEL(dut_lvl[1]), .DB_PULSE(dut_pls[1]), .ANY_PULSE(dut_any[1]));
  debounce_one_shot_multi #(.N(2), .CNT_W(8), .RISE_CLKS(4), .FALL_CLKS(3), .PULSE_CLKS(8), .MODE(2)) u_m2 (
    .CLK(clk), .RST_N(rst_n), .BTN(btn[2]), .DB_LEVEL(dut_lvl[2]), .DB_PULSE(dut_pls[2]), .ANY_PULSE(dut_any[2]));
  debounce_one_shot_multi #(.N(2), .CNT_W(4), .RISE_CLKS(1), .FALL_CLKS(15), .PULSE_CLKS(1), .MODE(2)) u_bnd (
    .CLK(clk), .RST_N(rst_n), .BTN(btn[3]), .DB_LEVEL(dut_lvl[3]), .DB_PULSE(dut_pls[3]), .ANY_PULSE(dut_any[3]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the level flips when the last TH sampled inputs all
  // disagree with it; the pulse is high while fewer than P edges have passed
  // since the latest qualifying flip.
  bit [63:0] m_bh   [NI][2];
  bit [63:0] m_sh   [NI][2];
  bit        m_lvl  [NI][2];
  bit        m_pls  [NI][2];
  int        m_last [NI][2];
  int        m_n    [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_n[i] = 0;
      for (int c = 0; c < 2; c++) begin
        m_bh[i][c]   = '0;
        m_sh[i][c]   = '0;
        m_lvl[i][c]  = 1'b0;
        m_pls[i][c]  = 1'b0;
        m_last[i][c] = -1000000;
      end
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      m_n[i]++;
      for (int c = 0; c < 2; c++) begin
        bit s, want, ok;
        int th;
        m_bh[i][c] = {m_bh[i][c][62:0], btn[i][c]};
        s          = m_bh[i][c][2];
        m_sh[i][c] = {m_sh[i][c][62:0], s};
        want       = !m_lvl[i][c];
        th         = want ? r_th[i] : f_th[i];
        ok         = (m_n[i] >= th);
        for (int j = 0; j < th; j++)
          if (m_sh[i][c][j] != want) ok = 1'b0;
        if (ok) begin
          m_lvl[i][c] = want;
          if ((want && (mode_v[i] == 1 || mode_v[i] == 2)) || (!want && mode_v[i] != 1))
            m_last[i][c] = m_n[i];
        end
        m_pls[i][c] = (m_n[i] - m_last[i][c]) < p_len[i];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("inst%0d DB_LEVEL", i), dut_lvl[i], {m_lvl[i][1], m_lvl[i][0]});
      check($sformatf("inst%0d DB_PULSE", i), dut_pls[i], {m_pls[i][1], m_pls[i][0]});
      check($sformatf("inst%0d ANY_PULSE", i), dut_any[i], m_pls[i][1] | m_pls[i][0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Called 1ns after an edge: asserts reset mid-cycle, checks, releases before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_lvl(input int inst, input int ch, input bit val, input int budget, output int n);
    n = 0;
    while (n < budget && dut_lvl[inst][ch] !== val) begin
      step();
      n++;
    end
  endtask

  typedef struct {
    bit btn;
    bit lvl;
    bit pls;
    bit any;
  } vec_t;

  function automatic vec_t mk(input bit b, input bit l, input bit p, input bit a);
    vec_t v;
    v.btn = b; v.lvl = l; v.pls = p; v.any = a;
    return v;
  endfunction

  initial begin
    vec_t tbl [9];
    bit   pat [8];
    int   n, any_cnt;

    tbl[0] = mk(1, 0, 0, 0); tbl[1] = mk(1, 0, 0, 0); tbl[2] = mk(1, 0, 0, 0);
    tbl[3] = mk(1, 0, 0, 0); tbl[4] = mk(1, 0, 0, 0); tbl[5] = mk(1, 1, 1, 1);
    tbl[6] = mk(1, 1, 1, 1); tbl[7] = mk(1, 1, 0, 0); tbl[8] = mk(1, 1, 0, 0);
    pat = '{1, 1, 1, 0, 1, 1, 1, 1};

    for (int i = 0; i < NI; i++) btn[i] = 2'b00;
    model_reset();
    #1;
    compare_all();
    repeat (3) step();
    #3 rst_n = 1'b1;

    // Clean press, MODE 1: level at edge 6, pulse edges 6-7
    for (int k = 0; k < 9; k++) begin
      btn[0][0] = tbl[k].btn;
      step();
      check($sformatf("t1 level e%0d", k + 1), dut_lvl[0][0], tbl[k].lvl);
      check($sformatf("t1 pulse e%0d", k + 1), dut_pls[0][0], tbl[k].pls);
      check($sformatf("t1 any e%0d", k + 1), dut_any[0], tbl[k].any);
      check($sformatf("t1 ch1 idle e%0d", k + 1), {dut_lvl[0][1], dut_pls[0][1]}, 2'b00);
    end

    // Reset during debounce and during an active pulse
    for (int i = 0; i < NI; i++) btn[i] = 2'b00;
    async_reset();
    btn[0] = 2'b01;
    repeat (4) step();
    check("t4 still debouncing", dut_lvl[0][0], 1'b0);
    async_reset();
    wait_lvl(0, 0, 1'b1, 20, n);
    check("t4 latency after reset", n, 6);
    check("t4 pulse before reset", dut_pls[0][0], 1'b1);
    async_reset();
    check("t4 pulse killed", dut_pls[0][0], 1'b0);
    btn[0] = 2'b00;
    repeat (3) step();

    // Simultaneous channels, MODE 1
    btn[0] = 2'b11;
    any_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("t5 pulses e%0d", k), dut_pls[0], (k == 6 || k == 7) ? 2'b11 : 2'b00);
      any_cnt += int'(dut_any[0]);
    end
    check("t5 any width", any_cnt, 2);

    // Bounce rejection, MODE 0
    for (int k = 0; k < 8; k++) begin
      btn[1][0] = pat[k];
      step();
      check($sformatf("t2 no early rise e%0d", k + 1), dut_lvl[1][0], 1'b0);
    end
    step();
    check("t2 no rise e9", dut_lvl[1][0], 1'b0);
    step();
    check("t2 rise e10", dut_lvl[1][0], 1'b1);
    check("t2 no press pulse", dut_pls[1][0], 1'b0);
    repeat (2) step();
    btn[1][0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2 hold through short low", dut_lvl[1][0], 1'b1);
    end
    btn[1][0] = 1'b1;
    step();
    check("t2 hold through glitch", dut_lvl[1][0], 1'b1);
    btn[1][0] = 1'b0;
    wait_lvl(1, 0, 1'b0, 20, n);
    check("t2 release latency", n, 8);
    check("t2 release pulse c1", dut_pls[1][0], 1'b1);
    step();
    check("t2 release pulse c2", dut_pls[1][0], 1'b1);
    step();
    check("t2 release pulse end", dut_pls[1][0], 1'b0);

    // MODE 2, long pulse restarted by release
    btn[2][0] = 1'b1;
    wait_lvl(2, 0, 1'b1, 20, n);
    check("t3 press latency", n, 6);
    check("t3 press pulse", dut_pls[2][0], 1'b1);
    btn[2][0] = 1'b0;
    for (int k = 7; k <= 19; k++) begin
      step();
      check($sformatf("t3 pulse e%0d", k), dut_pls[2][0], k <= 18);
      if (k == 10) check("t3 level before release", dut_lvl[2][0], 1'b1);
      if (k == 11) check("t3 level released", dut_lvl[2][0], 1'b0);
    end

    // Boundary: RISE 1, PULSE 1, FALL 15 on a 4-bit counter
    btn[3][0] = 1'b1;
    wait_lvl(3, 0, 1'b1, 20, n);
    check("t6 press latency", n, 3);
    check("t6 press pulse", dut_pls[3][0], 1'b1);
    step();
    check("t6 single-cycle pulse", dut_pls[3][0], 1'b0);
    btn[3][0] = 1'b0;
    wait_lvl(3, 0, 1'b0, 40, n);
    check("t6 release latency", n, 17);
    check("t6 release pulse", dut_pls[3][0], 1'b1);
    step();
    check("t6 release pulse end", dut_pls[3][0], 1'b0);

    // Randomised traffic on every instance against the model
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < 2; c++)
          if ($urandom_range(0, 9) == 0) btn[i][c] = !btn[i][c];
      if (k == 750) async_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
